// File: rtl/seq_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and counter sizing.
package seq_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A single-slice adder still needs a 1-bit counter to keep the vector legal.
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_adder_slice.sv
// DIGIT-bit ripple-carry slice; purely combinational.
module adder_slice #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT:0] w_c;

   assign w_c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]     = x[i] ^ y[i] ^ w_c[i];
      assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
   end

   assign co = w_c[DIGIT];

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder: adds DIGIT bits per cycle, LS slice first, result
// assembled by shifting slices into the sum register from the top.
module seq_adder
   import seq_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = cnt_bits(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_armed;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;

   logic             w_accept;
   logic             w_last;
   logic [DIGIT-1:0] w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_sum_nxt;

   adder_slice #(.DIGIT(DIGIT)) u_slice (
      .x  (r_a[DIGIT-1:0]),
      .y  (r_b[DIGIT-1:0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // r_armed blocks acceptance on the first edge after reset release.
   assign w_accept = (r_state == IDLE) && start && r_armed;
   assign w_last   = (r_cnt == LAST);

   if (N > 1) begin : g_shift
      assign w_sum_nxt = {w_s, r_sum[WIDTH-1:DIGIT]};
   end else begin : g_noshift
      assign w_sum_nxt = w_s;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = RUN;
         RUN:     if (w_last)   w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= (w_state_nxt == DONE);
         if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
         end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_co;
            r_sum   <= w_sum_nxt;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) r_cout <= w_co;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and sum width in bits; legal values are 2 to 64.
REQ-002 SHALL have parameter DIGIT, default 1: bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: operands, captured on an accepted start.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, captured on an accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse when the result is valid.
REQ-010 SHALL have port sum, output, WIDTH bits: result, held stable from done until the next accepted start.
REQ-011 SHALL have port cout, output, 1 bit: final carry-out, held with sum.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE; on acceptance, registers SHALL capture a, b and cin, clear the digit counter, and go to RUN.
REQ-014 SHALL, in RUN, add one DIGIT-bit slice per cycle, least-significant slice first, using the carry register as carry-in and storing the slice carry-out back to the carry register.
REQ-015 SHALL shift each slice result into the sum register MSB-first so that after the last slice sum holds {slice_N-1..slice_0}.
REQ-016 SHALL use a counter of ceil(log2(WIDTH/DIGIT)) bits; RUN SHALL end after exactly WIDTH/DIGIT cycles, then the FSM goes to DONE.
REQ-017 SHALL assert done for one cycle in DONE, then return to IDLE; latency from accepted start to done SHALL be WIDTH/DIGIT+1 cycles.
REQ-018 SHALL assert busy in RUN and DONE only.
REQ-019 SHALL ignore start while busy is high; inputs a, b and cin SHALL have no effect outside the accepting cycle.
REQ-020 SHALL accept a start asserted in the same cycle that the FSM returns to IDLE on the following edge, so back-to-back operations are WIDTH/DIGIT+2 cycles apart.
REQ-021 SHALL compute the result as exactly {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), with no overflow flag.
REQ-022 SHALL keep sum and cout unchanged until the next accepted start; partial values during RUN are don't-care to consumers.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously force state to IDLE and busy, done, sum, cout, the carry register and the counter to 0.
REQ-024 SHALL abort any operation in progress when rst_n is asserted mid-RUN; no done SHALL follow.
REQ-025 SHALL accept no start on the first rising edge at which rst_n is already high.

Structure
REQ-026 SHALL place the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) in shared package seq_adder_pkg.
REQ-027 SHALL instantiate one combinational sub-module, adder_slice, parameterised by DIGIT (a DIGIT-bit ripple of full-adder cells) with inputs x, y and ci and outputs s and co.
REQ-028 SHALL contain no combinational path from inputs to outputs; all outputs SHALL be registered.

Verification
REQ-029 SHALL cover: WIDTH=8, DIGIT=1, a=8'hFF, b=8'h01, cin=0 -> done at cycle 9 after start, sum=8'h00, cout=1.
REQ-030 SHALL cover: WIDTH=8, DIGIT=4, a=8'h3C, b=8'hA5, cin=1 -> done at cycle 3, sum=8'hE2, cout=0.
REQ-031 SHALL cover: start pulsed again mid-RUN with different operands -> ignored; the result matches the first operands only.
REQ-032 SHALL cover: rst_n pulsed low at RUN cycle 4 -> busy=0, sum=0, no done; the next start completes normally.
REQ-033 SHALL cover: start held high continuously, a=8'h80, b=8'h80 -> done every 10 cycles, each with sum=8'h00, cout=1.
REQ-034 SHALL cover: exhaustive WIDTH=4, DIGIT=2 sweep over all a, b and cin (512 cases) -> {cout,sum} equals a+b+cin for each case.
